// File: rtl/spi_tx_arbiter.sv
// rtl/spi_tx_arbiter.sv - round-robin arbiter sharing one spi_tx serializer among N_REQ requesters
// Captures one frame at a time, hands it to spi_tx, and reports completion once the serializer is idle.
module spi_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int IDW        = 2,
  parameter int DW         = 24,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  RSTn,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic [DW-1:0]         spi_bus_data,
  output logic                  spi_bus_vld,
  input  logic                  spi_rdy,
  output logic                  done_valid,
  output logic [IDW-1:0]        done_id,
  output logic                  busy,
  output logic [CNT_W-1:0]      frames_sent
);

  typedef enum logic [1:0] {
    S_ARB  = 2'd0,
    S_SEND = 2'd1,
    S_BUSY = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [IDW-1:0]         last_id;
  logic [IDW-1:0]         grant_id;
  logic [7:0]             gap_cnt;

  logic [IDW-1:0]         start_idx;
  logic [2*N_REQ-1:0]     rot_valid;
  logic [IDW-1:0]         offs;
  logic [IDW:0]           grant_sum;
  logic [IDW-1:0]         grant;
  logic                   any_req;
  logic                   bus_hs;

  assign any_req = |req_valid;
  assign bus_hs  = spi_bus_vld && spi_rdy;
  assign busy    = (state != S_ARB);

  // Rotate the request vector so the slot after last_id sits at bit 0, then take the lowest set bit.
  always_comb begin
    start_idx = (last_id == IDW'(N_REQ - 1)) ? '0 : last_id + 1'b1;
    rot_valid = {req_valid, req_valid} >> start_idx;
    offs      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_valid[i]) begin
        offs = IDW'(i);
      end
    end
    grant_sum = {1'b0, start_idx} + {1'b0, offs};
    if (grant_sum >= (IDW+1)'(N_REQ)) begin
      grant = IDW'(grant_sum - (IDW+1)'(N_REQ));
    end else begin
      grant = grant_sum[IDW-1:0];
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state <= S_ARB;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      S_ARB: begin
        if (any_req) begin
          req_ready[grant] = 1'b1;
          state_nxt        = S_SEND;
        end
      end
      S_SEND: begin
        if (bus_hs) begin
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (spi_rdy) begin
          state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_ARB;
        end
      end
      S_GAP: begin
        if (gap_cnt <= 8'd1) begin
          state_nxt = S_ARB;
        end
      end
      default: state_nxt = S_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      last_id      <= IDW'(N_REQ - 1);
      grant_id     <= '0;
      gap_cnt      <= '0;
      spi_bus_vld  <= 1'b0;
      spi_bus_data <= '0;
      done_valid   <= 1'b0;
      done_id      <= '0;
      frames_sent  <= '0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        S_ARB: begin
          if (any_req) begin
            spi_bus_data <= req_data[grant*DW +: DW];
            grant_id     <= grant;
            last_id      <= grant;
            spi_bus_vld  <= 1'b1;
          end
        end
        S_SEND: begin
          if (bus_hs) begin
            spi_bus_vld <= 1'b0;
          end
        end
        S_BUSY: begin
          // spi_rdy only returns high once the serializer has finished shifting
          if (spi_rdy) begin
            done_valid  <= 1'b1;
            done_id     <= grant_id;
            frames_sent <= frames_sent + 1'b1;
            gap_cnt     <= 8'(GAP_CYCLES);
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb/tb_spi_tx_arbiter.sv - randomized self-checking bench for spi_tx_arbiter with a behavioural spi_tx stand-in
module tb_spi_tx_arbiter;
  localparam int N   = 4;
  localparam int DW  = 24;
  localparam int GAP = 3;
  localparam int CW  = 4;

  logic            clk = 1'b0;
  logic            RSTn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   spi_bus_data;
  logic            spi_bus_vld;
  logic            spi_rdy;
  logic            done_valid;
  logic [1:0]      done_id;
  logic            busy;
  logic [CW-1:0]   frames_sent;

  int total = 0;
  int bad   = 0;

  spi_tx_arbiter #(.N_REQ(N), .IDW(2), .DW(DW), .GAP_CYCLES(GAP), .CNT_W(CW)) dut (
    .clk(clk), .RSTn(RSTn), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .spi_bus_data(spi_bus_data), .spi_bus_vld(spi_bus_vld), .spi_rdy(spi_rdy),
    .done_valid(done_valid), .done_id(done_id), .busy(busy), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // spi_tx stand-in: idle-high ready, drops for a random shift time after accepting a word
  logic [DW-1:0] last_word;
  int            shift_cnt;
  always @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      spi_rdy   <= 1'b1;
      shift_cnt <= 0;
      last_word <= '0;
    end else if (spi_rdy && spi_bus_vld) begin
      spi_rdy   <= 1'b0;
      last_word <= spi_bus_data;
      shift_cnt <= $urandom_range(2, 8);
    end else if (!spi_rdy) begin
      if (shift_cnt == 0) spi_rdy <= 1'b1;
      else shift_cnt <= shift_cnt - 1;
    end
  end

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Reference model: one frame in flight; arbitration opens GAP cycles after each completion.
  int            cyc = 0;
  bit            idle_m, exp_vld, shifting, done_exp, elig;
  int            free_cyc, last_m, fs_m, done_cnt, exp_id, last_done_id, g;
  logic [DW-1:0] exp_data;
  logic [N-1:0]  exp_rr;

  always @(negedge clk) begin
    cyc++;
    if (!RSTn) begin
      idle_m = 1; free_cyc = 0; last_m = N - 1; exp_vld = 0; shifting = 0;
      done_exp = 0; fs_m = 0; done_cnt = 0;
    end else begin
      chk("done_valid", done_valid, done_exp);
      if (done_exp) begin
        fs_m++; done_cnt++;
        chk("done_id", done_id, exp_id);
        chk("frames_sent", frames_sent, fs_m % (1 << CW));
        last_done_id = done_id;
        idle_m = 1; free_cyc = cyc + GAP;
      end
      done_exp = 0;
      elig = idle_m && (cyc >= free_cyc);
      chk("busy", busy, !elig);
      g = rr_pick(last_m, req_valid);
      exp_rr = (elig && g >= 0) ? N'(1 << g) : '0;
      chk("req_ready", req_ready, exp_rr);
      chk("spi_bus_vld", spi_bus_vld, exp_vld);
      if (exp_vld) chk("spi_bus_data", spi_bus_data, exp_data);
      if (shifting && spi_rdy) begin done_exp = 1; shifting = 0; end
      if (exp_vld && spi_rdy) begin exp_vld = 0; shifting = 1; end
      if (exp_rr != '0) begin
        idle_m = 0; exp_vld = 1; last_m = g; exp_id = g;
        exp_data = req_data[g*DW +: DW];
      end
    end
  end

  logic [N-1:0] rr_s;
  task automatic drive_cycle(input logic [N-1:0] mask, input bit churn);
    @(negedge clk);
    rr_s = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rr_s[i]) begin
        req_valid[i] = mask[i] && (!churn || ($urandom_range(0, 1) == 1));
        req_data[i*DW +: DW] = DW'($urandom);
      end else if (!req_valid[i]) begin
        if (mask[i] && (!churn || ($urandom_range(0, 2) == 0))) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = DW'($urandom);
        end
      end else if (!mask[i] || (churn && ($urandom_range(0, 7) == 0))) begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", spi_bus_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames_sent, 0);
    chk("rst_data", spi_bus_data, 0);
    RSTn = 1'b1;

    // single frame on ch2
    req_data[2*DW +: DW] = 24'hA5C3F0;
    req_valid = 4'b0100;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = req_ready[2];
      @(posedge clk);
      #1;
      if (seen) req_valid = '0;
    end
    chk("t1_granted", seen, 1);
    repeat (40) drive_cycle('0, 0);
    chk("t1_word", last_word, 24'hA5C3F0);
    chk("t1_done_id", last_done_id, 2);
    chk("t1_frames", frames_sent, 1);

    repeat (150) drive_cycle(4'b1111, 0);
    repeat (30)  drive_cycle('0, 0);
    repeat (150) drive_cycle(4'b1010, 0);
    repeat (400) drive_cycle(4'b1111, 1);

    // reset in the middle of a ch1 frame
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      drive_cycle(4'b0010, 0);
      seen = shifting && (exp_id == 1);
    end
    chk("mid_wait", seen, 1);
    #2;
    req_valid = '0;
    RSTn = 1'b0;
    #1;
    chk("mr_vld", spi_bus_vld, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done_valid, 0);
    chk("mr_frames", frames_sent, 0);
    chk("mr_ready", req_ready, 0);
    chk("mr_data", spi_bus_data, 0);
    repeat (3) begin
      @(negedge clk);
      chk("mr_hold_done", done_valid, 0);
    end
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    #1;
    RSTn = 1'b1;
    repeat (60) drive_cycle(4'b1111, 0);

    // counter wrap: restart and run 17 frames on ch0
    repeat (30) drive_cycle('0, 0);
    #2;
    RSTn = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    RSTn = 1'b1;
    n = 0;
    while (done_cnt < 17 && n < 2000) begin
      drive_cycle(4'b0001, 0);
      n++;
    end
    chk("wrap_reached", done_cnt, 17);
    chk("wrap_frames", frames_sent, 1);
    req_valid = '0;
    repeat (30) drive_cycle('0, 0);
    chk("wrap_total", done_cnt, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
